// File: rtl/uart_rx_pkg.sv
// Shared FSM state encoding and sample-point / parity / saturation helpers for the UART receive monitor.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } rx_state_e;

    // Counter value at which the start bit is sampled (half a bit after the edge).
    function automatic int mid_sample(input int clks_per_bit);
        return clks_per_bit / 32'sd2 - 32'sd1;
    endfunction

    // Counter value at which every later bit is sampled (one full bit period apart).
    function automatic int full_sample(input int clks_per_bit);
        return clks_per_bit - 32'sd1;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte buffer: wrap-around pointers with an extra MSB to tell full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; both may move in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Storage write; contents are never observed while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver with frame/parity error accounting feeding a small byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic                 o_frame_err,
    output logic                 o_overflow,
    output logic [7:0]           o_err_cnt
);
    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(mid_sample(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(full_sample(CLKS_PER_BIT));

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 prev_r;
    rx_state_e            state_r;
    logic [CNT_W-1:0]     clk_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 push_r;
    logic                 frame_err_r;
    logic                 overflow_r;
    logic [7:0]           err_cnt_r;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic [DATA_BITS-1:0] fifo_data_s;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= i_rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Frame decoder; push and frame-error are single-cycle registered strobes
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r     <= ST_IDLE;
            clk_cnt_r   <= '0;
            bit_cnt_r   <= 4'd0;
            shift_r     <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                    if (prev_r && !sync2_r) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt_r == MID_CNT) begin
                        clk_cnt_r <= '0;
                        state_r   <= sync2_r ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_r == FULL_CNT) begin
                        clk_cnt_r <= '0;
                        shift_r   <= {sync2_r, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                            bit_cnt_r <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            state_r   <= ST_PARITY;
`else
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt_r == FULL_CNT) begin
                        clk_cnt_r <= '0;
                        if (sync2_r != even_parity(8'(shift_r))) begin
                            err_cnt_r <= sat_inc8(err_cnt_r);
                            state_r   <= ST_RECOVER;
                        end else begin
                            state_r   <= ST_STOP;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt_r == FULL_CNT) begin
                        clk_cnt_r <= '0;
                        if (!sync2_r) begin
                            frame_err_r <= 1'b1;
                            err_cnt_r   <= sat_inc8(err_cnt_r);
                            state_r     <= ST_RECOVER;
                        end else if (bit_cnt_r == 4'(STOP_BITS - 1)) begin
                            push_r      <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            bit_cnt_r   <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                // A held-low line (break) waits here so it counts as one error only
                ST_RECOVER: begin
                    if (sync2_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop_s = !empty_s && i_rdy;

    // Sticky overflow: a good byte arrived with no room and no same-cycle pop
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            overflow_r <= 1'b0;
        end else if (push_r && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .push  (push_r),
        .pop   (pop_s),
        .wdata (shift_r),
        .rdata (fifo_data_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign o_data      = fifo_data_s;
    assign o_vld       = !empty_s;
    assign o_frame_err = frame_err_r;
    assign o_overflow  = overflow_r;
    assign o_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor (4 clocks/bit, 8N1, 4-entry FIFO).
// Frames follow the even-parity format when UART_RX_PARITY_EN is defined.
module tb_uart_rx_monitor;
    localparam int CPB = 4;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       i_rx;
    logic       i_rdy;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_frame_err;
    logic       o_overflow;
    logic [7:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

    byte unsigned got_q[$];
    int ferr_pulses = 0;
    int vld_cycles  = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pops;
        int         exp_err;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 wb_clk = ~wb_clk;

    // Observe consumer handshakes and strobes away from the active edge
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (o_vld && i_rdy) got_q.push_back(o_data);
            if (o_frame_err) ferr_pulses++;
            if (o_vld) vld_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        i_rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^d : ~(^d));
`endif
        drive_bit(stop);
        i_rx = 1'b1;
        tick(8);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int base_q;
        int base_f;
        int base_v;

        vecs[0] = '{8'h55, 1'b1, 1, 0, 0};
        vecs[1] = '{8'hA3, 1'b0, 0, 1, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 1, 0};
        vecs[4] = '{8'h80, 1'b0, 0, 2, 1};
        vecs[5] = '{8'h3C, 1'b1, 1, 2, 0};

        wb_rst = 1'b1;
        i_rx   = 1'b1;
        i_rdy  = 1'b1;
        tick(4);
        wb_rst = 1'b0;
        tick(4);
        check("rst_vld", o_vld, 0);
        check("rst_data", o_data, 0);
        check("rst_ferr", o_frame_err, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_errcnt", o_err_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            base_q = got_q.size();
            base_f = ferr_pulses;
            base_v = vld_cycles;
            send_frame(vecs[i].data, vecs[i].stop, 1'b1);
            check("vec_pops", got_q.size() - base_q, vecs[i].exp_pops);
            if (vecs[i].exp_pops == 1 && got_q.size() > base_q)
                check("vec_data", got_q[base_q], vecs[i].data);
            check("vec_vld_cycles", vld_cycles - base_v, vecs[i].exp_pops);
            check("vec_ferr", ferr_pulses - base_f, vecs[i].exp_ferr);
            check("vec_errcnt", o_err_cnt, vecs[i].exp_err);
            check("vec_empty", o_vld, 0);
        end

        // One-cycle low glitch is a false start
        base_q = got_q.size();
        base_f = ferr_pulses;
        i_rx = 1'b0;
        tick(1);
        i_rx = 1'b1;
        tick(12);
        check("false_pops", got_q.size() - base_q, 0);
        check("false_ferr", ferr_pulses - base_f, 0);
        check("false_errcnt", o_err_cnt, 2);

        // Long break counts as exactly one frame error
        base_q = got_q.size();
        base_f = ferr_pulses;
        i_rx = 1'b0;
        tick(60);
        i_rx = 1'b1;
        tick(10);
        check("break_ferr", ferr_pulses - base_f, 1);
        check("break_errcnt", o_err_cnt, 3);
        check("break_pops", got_q.size() - base_q, 0);

        // Fill a 4-deep FIFO with the consumer stalled, then overflow it
        i_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        check("full_no_ovf", o_overflow, 0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("ovf_set", o_overflow, 1);
        check("ovf_vld", o_vld, 1);
        check("ovf_head_stable", o_data, 8'h01);
        base_q = got_q.size();
        i_rdy = 1'b1;
        tick(8);
        check("drain_pops", got_q.size() - base_q, 4);
        for (int i = 0; i < 4; i++)
            if (got_q.size() > base_q + i) check("drain_data", got_q[base_q + i], 32'(i + 1));
        check("drain_empty", o_vld, 0);
        check("ovf_sticky", o_overflow, 1);

        // Reset in the middle of the 4th data bit of 0xFF
        base_q = got_q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        tick(2);
        wb_rst = 1'b1;
        tick(2);
        wb_rst = 1'b0;
        tick(1);
        check("midrst_vld", o_vld, 0);
        check("midrst_data", o_data, 0);
        check("midrst_ferr", o_frame_err, 0);
        check("midrst_ovf", o_overflow, 0);
        check("midrst_errcnt", o_err_cnt, 0);
        tick(40);
        check("midrst_no_partial", got_q.size() - base_q, 0);
        send_frame(8'h12, 1'b1, 1'b1);
        check("after_rst_pops", got_q.size() - base_q, 1);
        if (got_q.size() > base_q) check("after_rst_data", got_q[base_q], 8'h12);
        check("after_rst_errcnt", o_err_cnt, 0);

`ifdef UART_RX_PARITY_EN
        base_q = got_q.size();
        base_f = ferr_pulses;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_pops", got_q.size() - base_q, 0);
        check("par_errcnt", o_err_cnt, 1);
        check("par_no_ferr", ferr_pulses - base_f, 0);
`endif

        // Error counter saturates at 255
        base_f = ferr_pulses;
        for (int i = 0; i < 260; i++) send_frame(8'h00, 1'b0, 1'b1);
        check("sat_errcnt", o_err_cnt, 8'hFF);
        check("sat_ferr_pulses", ferr_pulses - base_f, 260);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, wb_clk cycles per UART bit (legal >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, received-byte buffer entries (power of two, >= 2).
REQ-005 SHALL have port wb_clk  input  1  sole clock.
REQ-006 SHALL have port wb_rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port o_data  output  DATA_BITS  FIFO head byte.
REQ-009 SHALL have port o_vld  output  1  FIFO non-empty.
REQ-010 SHALL have port i_rdy  input  1  consumer accepts head when o_vld.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse per frame with bad stop bit.
REQ-012 SHALL have port o_overflow  output  1  sticky; a good frame was dropped because the FIFO was full.
REQ-013 SHALL have port o_err_cnt  output  8  saturating count of frame and parity errors.

Function
REQ-014 SHALL pass i_rx through a 2-flop synchroniser; all decoding uses the synchronised bit.
REQ-015 SHALL implement FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus RECOVER.
REQ-016 SHALL leave IDLE on a synchronised 1->0 transition; bit counter restarts at 0.
REQ-017 SHALL sample START at CLKS_PER_BIT/2 cycles after the edge; a sampled 1 is a false start -> IDLE, no error.
REQ-018 SHALL sample each subsequent bit every CLKS_PER_BIT cycles; data is LSB first, DATA_BITS bits.
REQ-019 SHALL sample STOP_BITS stop bits; any sampled 0 -> frame discarded, o_frame_err pulse, error count +1, enter RECOVER.
REQ-020 SHALL stay in RECOVER until synchronised rx is high, then go to IDLE; a break (continuous low) yields exactly one frame error.
REQ-021 SHALL push a good frame into the FIFO the cycle after the last stop-bit sample; o_vld rises the following cycle.
REQ-022 SHALL, on a good frame with the FIFO full and no same-cycle pop, drop the byte and set o_overflow.
REQ-023 SHALL accept the push when full if a pop occurs in the same cycle.
REQ-024 SHALL pop on o_vld && i_rdy; o_data SHALL be stable while o_vld && !i_rdy.
REQ-025 SHALL hold o_err_cnt at 255 once reached.
REQ-026 SHALL use wrap-around read and write pointers with an extra MSB for full/empty distinction.

Reset
REQ-027 SHALL, on wb_rst, return the FSM to IDLE, synchroniser flops to 1, FIFO empty, o_vld 0, o_data 0, o_frame_err 0, o_overflow 0, o_err_cnt 0.
REQ-028 SHALL abandon a frame in progress when reset is asserted mid-frame; no partial byte is pushed.

Configuration
REQ-029 SHALL, with UART_RX_PARITY_EN defined, include the PARITY state: one even-parity bit after the data; a mismatch discards the frame and increments o_err_cnt, without o_frame_err.
REQ-030 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and the parity logic; frames are start, data, stop only.

Structure
REQ-031 SHALL place FSM state enum and sample-point constant helpers in shared package uart_rx_pkg.
REQ-032 SHALL implement the buffer as sub-module uart_rx_fifo (parametrised width/depth, push/pop/full/empty).

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
REQ-033 SHALL cover: frame 0x55 with i_rdy=1 -> o_vld for one cycle with o_data=0x55, o_err_cnt=0.
REQ-034 SHALL cover: i_rx low for 1 cycle then high -> false start, no push, no error.
REQ-035 SHALL cover: frame 0xA3 with stop bit 0 -> o_frame_err one cycle, o_err_cnt=1, FIFO empty.
REQ-036 SHALL cover: 5 frames 0x01..0x05 with i_rdy=0 -> o_overflow=1; draining yields 0x01..0x04.
REQ-037 SHALL cover: reset asserted at the 4th data bit of 0xFF -> outputs at reset values; next frame 0x12 is received correctly.
REQ-038 SHALL cover, with UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> discarded, o_err_cnt=1, o_frame_err stays 0.
